// File: rtl/video_timing_gen_if.sv
// Signal bundle between the raster timing generator and its consumers
// (framebuffer read port, output encoder, pixel-rate enable source).
interface video_timing_gen_if #(
  parameter int H_W    = 12,
  parameter int V_W    = 11,
  parameter int ADDR_W = 19
);
  logic              iEn;
  logic              oDE;
  logic              oHS;
  logic              oVS;
  logic [H_W-1:0]    oX;
  logic [V_W-1:0]    oY;
  logic [ADDR_W-1:0] oAddr;
  logic              oFrameStart;
  logic              oLineStart;

  modport master (
    input  iEn,
    output oDE, oHS, oVS, oX, oY, oAddr, oFrameStart, oLineStart
  );

  modport slave (
    output iEn,
    input  oDE, oHS, oVS, oX, oY, oAddr, oFrameStart, oLineStart
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: DE/HSYNC/VSYNC, pixel coordinates,
// line/frame strobes and a multiplier-free upscaling framebuffer address.
module video_timing_gen #(
  parameter int H_VA     = 640,
  parameter int H_FP     = 16,
  parameter int H_SP     = 96,
  parameter int H_BP     = 48,
  parameter int V_VA     = 480,
  parameter int V_FP     = 10,
  parameter int V_SP     = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int SCALE_SH = 0,
  parameter int H_W      = 12,
  parameter int V_W      = 11,
  parameter int ADDR_W   = 19
) (
  input  logic              iClk,
  input  logic              iRst,
  video_timing_gen_if.master vid
);

  localparam int H_TOT = H_VA + H_FP + H_SP + H_BP;
  localparam int V_TOT = V_VA + V_FP + V_SP + V_BP;

  if (SCALE_SH < 0 || SCALE_SH > 3) begin : g_bad_scale
    $error("video_timing_gen: SCALE_SH must be 0..3");
  end
  if ((H_VA % (1 << SCALE_SH)) != 0 || (V_VA % (1 << SCALE_SH)) != 0) begin : g_bad_div
    $error("video_timing_gen: H_VA and V_VA must be divisible by 2^SCALE_SH");
  end
  if (64'((H_VA >> SCALE_SH) * (V_VA >> SCALE_SH)) > (64'(1) << ADDR_W)) begin : g_bad_addr
    $error("video_timing_gen: framebuffer does not fit in ADDR_W");
  end
  if (64'(H_TOT - 1) >= (64'(1) << H_W) || 64'(V_TOT - 1) >= (64'(1) << V_W)) begin : g_bad_cnt
    $error("video_timing_gen: counter width too small for the raster totals");
  end

  // Thresholds kept 32-bit unsigned so a zero-width porch cannot overflow the counter width.
  localparam logic [31:0]       H_ACT_U   = 32'(H_VA);
  localparam logic [31:0]       HS_BEG_U  = 32'(H_VA + H_FP);
  localparam logic [31:0]       HS_END_U  = 32'(H_VA + H_FP + H_SP);
  localparam logic [31:0]       V_ACT_U   = 32'(V_VA);
  localparam logic [31:0]       V_ROWS_U  = 32'(V_VA - 1);
  localparam logic [31:0]       VS_BEG_U  = 32'(V_VA + V_FP);
  localparam logic [31:0]       VS_END_U  = 32'(V_VA + V_FP + V_SP);
  localparam logic [H_W-1:0]    H_LAST    = H_W'(H_TOT - 1);
  localparam logic [V_W-1:0]    V_LAST    = V_W'(V_TOT - 1);
  localparam logic [V_W-1:0]    S_MASK    = V_W'((1 << SCALE_SH) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(H_VA >> SCALE_SH);
  localparam logic              HS_ACT    = (HS_POL != 0);
  localparam logic              VS_ACT    = (VS_POL != 0);

  logic [H_W-1:0]    h_cnt_q, h_cnt_d;
  logic [V_W-1:0]    v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [H_W-1:0]    x_q, x_d;
  logic [V_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fs_q, fs_d, ls_q, ls_d;

  logic h_last, v_last, active, in_hs, in_vs, row_adv;

  always_comb begin
    h_last  = (h_cnt_q == H_LAST);
    v_last  = (v_cnt_q == V_LAST);
    active  = (32'(h_cnt_q) < H_ACT_U) && (32'(v_cnt_q) < V_ACT_U);
    in_hs   = (32'(h_cnt_q) >= HS_BEG_U) && (32'(h_cnt_q) < HS_END_U);
    in_vs   = (32'(v_cnt_q) >= VS_BEG_U) && (32'(v_cnt_q) < VS_END_U);
    // Advance the row base only after the last replicated copy of a framebuffer row.
    row_adv = (32'(v_cnt_q) < V_ROWS_U) && ((v_cnt_q & S_MASK) == S_MASK);

    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    row_base_d = row_base_q;
    de_d       = de_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = addr_q;
    fs_d       = 1'b0;
    ls_d       = 1'b0;

    if (vid.iEn) begin
      h_cnt_d = h_last ? '0 : h_cnt_q + H_W'(1);
      if (h_last) begin
        v_cnt_d = v_last ? '0 : v_cnt_q + V_W'(1);
        if (v_last)       row_base_d = '0;
        else if (row_adv) row_base_d = row_base_q + ROW_STEP;
      end
      de_d   = active;
      hs_d   = in_hs ? HS_ACT : ~HS_ACT;
      vs_d   = in_vs ? VS_ACT : ~VS_ACT;
      x_d    = h_cnt_q;
      y_d    = v_cnt_q;
      addr_d = active ? row_base_q + ADDR_W'(h_cnt_q >> SCALE_SH) : '0;
      fs_d   = (h_cnt_q == '0) && (v_cnt_q == '0);
      ls_d   = (h_cnt_q == '0);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      row_base_q <= '0;
      de_q       <= 1'b0;
      hs_q       <= ~HS_ACT;
      vs_q       <= ~VS_ACT;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      fs_q       <= 1'b0;
      ls_q       <= 1'b0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      row_base_q <= row_base_d;
      de_q       <= de_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      x_q        <= x_d;
      y_q        <= y_d;
      addr_q     <= addr_d;
      fs_q       <= fs_d;
      ls_q       <= ls_d;
    end
  end

  assign vid.oDE         = de_q;
  assign vid.oHS         = hs_q;
  assign vid.oVS         = vs_q;
  assign vid.oX          = x_q;
  assign vid.oY          = y_q;
  assign vid.oAddr       = addr_q;
  assign vid.oFrameStart = fs_q;
  assign vid.oLineStart  = ls_q;

endmodule
